// File: rtl/pce_punc_enc_if.sv
// pce_punc_enc_if: bit-serial info input and coded output bundle of the punctured encoder
interface pce_punc_enc_if #(
  parameter int CBPS_W = 9,
  parameter int SYM_W = 4
);
  logic di;
  logic di_vld;
  logic di_last;
  logic di_rdy;
  logic [1:0] rate;
  logic [CBPS_W-1:0] n_cbps;
  logic dout;
  logic do_vld;
  logic [SYM_W-1:0] do_sym_num;
  logic done;
  modport master (output di, di_vld, di_last, rate, n_cbps, input di_rdy, dout, do_vld, do_sym_num, done);
  modport slave (input di, di_vld, di_last, rate, n_cbps, output di_rdy, dout, do_vld, do_sym_num, done);
endinterface

// File: rtl/pce_punc_enc.sv
// pce_punc_enc: convolutional encoder with puncturing, K-1 zero tail and OFDM symbol padding
module pce_punc_enc #(
  parameter int K = 7,
  parameter logic [K-1:0] G0 = 7'o133,
  parameter logic [K-1:0] G1 = 7'o171,
  parameter int CBPS_W = 9,
  parameter int SYM_W = 4
) (
  input logic clk,
  input logic rst,
  pce_punc_enc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ENC, TAIL, PAD} state_t;
  localparam int TW = $clog2(K);
  state_t st;
  logic [K-2:0] sr;
  logic [1:0] pend, pcnt, ph, rate_r, ph_c, per, nk, tot, nb, rate_c;
  logic [CBPS_W-1:0] cnt, ncbps_r, cnt_c, ncbps_c;
  logic [SYM_W-1:0] sym, sym_c;
  logic [TW-1:0] tcnt;
  logic [2:0] q;
  logic dout_r, vld_r, done_r;
  logic idle, rdy, acc, enc, in_bit, a, b, ka, kb, pad, pop, wrap;
  assign idle = st == IDLE;
  assign rdy = !rst && !done_r && (idle || (st == ENC && pcnt <= 2'd1));
  assign acc = rdy && bus.di_vld;
  assign enc = acc || (st == TAIL && pcnt <= 2'd1);
  assign in_bit = acc & bus.di;
  assign a = ^(G0 & {in_bit, sr});
  assign b = ^(G1 & {in_bit, sr});
  // a new frame sees cleared counters and the live rate/n_cbps in its first cycle
  assign rate_c = idle ? bus.rate : rate_r;
  assign ncbps_c = idle ? bus.n_cbps : ncbps_r;
  assign cnt_c = idle ? '0 : cnt;
  assign ph_c = idle ? '0 : ph;
  assign sym_c = acc && idle ? '0 : sym;
  assign per = rate_c == 2'b01 ? 2'd2 : rate_c == 2'b10 ? 2'd3 : 2'd1;
  assign ka = enc && ph_c != 2'd2;
  assign kb = enc && ph_c != 2'd1;
  assign nk = {1'b0, ka} + {1'b0, kb};
  assign nb = ka ? {b, a} : {1'b0, b};
  assign q = pcnt == 2'd0 ? {1'b0, nb} : pcnt == 2'd1 ? {nb, pend[0]} : {1'b0, pend};
  assign tot = pcnt + nk;
  assign pad = st == PAD && tot == 2'd0 && cnt != '0 && ncbps_r != '0;
  assign pop = tot != 2'd0 || pad;
  assign wrap = pop && ncbps_c != '0 && cnt_c == ncbps_c - CBPS_W'(1);
  assign bus.di_rdy = rdy;
  assign bus.dout = dout_r;
  assign bus.do_vld = vld_r;
  assign bus.done = done_r;
  assign bus.do_sym_num = sym;
  always_ff @(posedge clk)
    if (rst) begin
      st <= IDLE;
      sr <= '0;
      pend <= '0;
      pcnt <= '0;
      ph <= '0;
      rate_r <= '0;
      ncbps_r <= '0;
      cnt <= '0;
      sym <= '0;
      tcnt <= '0;
      dout_r <= 1'b0;
      vld_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      dout_r <= pop && !pad && q[0];
      vld_r <= pop;
      done_r <= st == PAD && !pop;
      pend <= q[2:1];
      pcnt <= tot == 2'd0 ? 2'd0 : tot - 2'd1;
      sym <= sym_c + SYM_W'(wrap);
      if (pop) cnt <= wrap ? '0 : cnt_c + CBPS_W'(1);
      if (enc) begin
        sr <= {in_bit, sr[K-2:1]};
        ph <= ph_c == per - 2'd1 ? 2'd0 : ph_c + 2'd1;
      end
      if (acc && idle) begin
        rate_r <= bus.rate;
        ncbps_r <= bus.n_cbps;
      end
      tcnt <= acc ? '0 : st == TAIL && enc ? tcnt + TW'(1) : tcnt;
      st <= acc ? (bus.di_last ? TAIL : ENC) :
            st == TAIL && enc && tcnt == TW'(K - 2) ? PAD :
            st == PAD && !pop ? IDLE : st;
    end
endmodule

// File: tb/tb_pce_punc_enc.sv
// tb_pce_punc_enc: directed frames checked against a behavioural encoder model via a bit scoreboard
module tb_pce_punc_enc;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  pce_punc_enc_if #(.CBPS_W(9), .SYM_W(4)) bus ();
  pce_punc_enc dut (.clk(clk), .rst(rst), .bus(bus));
  int n_tests = 0, n_fail = 0;
  int cyc = 0, vld_cnt = 0, done_cnt = 0, first_vld = -1, last_vld = -1, done_cyc = -1;
  int first_acc = -1, exp_len = 0, prev_done = -1;
  bit sb_on = 1;
  bit src[$];
  bit exp_q[$];
  logic [63:0] cap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (bus.do_vld && sb_on) begin
      if (vld_cnt == 0) first_vld = cyc;
      last_vld = cyc;
      vld_cnt++;
      cap = {cap[62:0], bus.dout};
      if (exp_q.size() == 0) chk("extra_bit", 1, 0);
      else chk("do_bit", 32'(bus.dout), 32'(exp_q.pop_front()));
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("rdy_in_done", 32'(bus.di_rdy), 0);
    end
  end

  task automatic model(input logic [1:0] r, input int ncbps);
    logic [5:0] sr = '0;
    logic [6:0] v;
    int ph = 0, per, len = 0;
    bit x;
    per = r == 2'b01 ? 2 : r == 2'b10 ? 3 : 1;
    for (int i = 0; i < src.size() + 6; i++) begin
      x = i < src.size() ? src[i] : 1'b0;
      v = {x, sr};
      if (ph != 2) begin exp_q.push_back(^(v & 7'o133)); len++; end
      if (ph != 1) begin exp_q.push_back(^(v & 7'o171)); len++; end
      sr = {x, sr[5:1]};
      ph = (ph + 1) % per;
    end
    while (ncbps != 0 && len % ncbps != 0) begin exp_q.push_back(1'b0); len++; end
    exp_len = len;
  endtask

  task automatic send(input logic [1:0] r, input int ncbps);
    int k = 0, guard = 0;
    bit rd;
    bus.rate = r;
    bus.n_cbps = 9'(ncbps);
    while (k < src.size()) begin
      bus.di = src[k];
      bus.di_last = k == src.size() - 1;
      bus.di_vld = 1;
      @(negedge clk) rd = bus.di_rdy;
      @(posedge clk);
      if (rd && k == 0) first_acc = cyc;
      #1;
      if (rd) begin
        k++;
        bus.rate = 2'($urandom);
        bus.n_cbps = 9'($urandom);
      end
      if (++guard > 2000) begin chk("send_timeout", 1, 0); break; end
    end
    bus.di_vld = 0;
    bus.di_last = 0;
    bus.di = 0;
  endtask

  task automatic frame(input string tag, input logic [1:0] r, input int ncbps, input bit b2b);
    int g = 0;
    vld_cnt = 0; done_cnt = 0; first_vld = -1; cap = '0;
    model(r, ncbps);
    send(r, ncbps);
    if (b2b) begin
      chk({tag, "_b2b_accept"}, first_acc, prev_done + 1);
      chk({tag, "_sym_restart"}, 32'(bus.do_sym_num), 0);
    end
    while (done_cnt == 0 && g < 3000) begin @(posedge clk); #1; g++; end
    chk({tag, "_done_seen"}, 32'(done_cnt != 0), 1);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_len"}, vld_cnt, exp_len);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
    chk({tag, "_contig"}, last_vld - first_vld + 1, vld_cnt);
    chk({tag, "_latency"}, first_vld, first_acc + 1);
    chk({tag, "_done_time"}, done_cyc, last_vld + 1);
    chk({tag, "_sym"}, 32'(bus.do_sym_num), ncbps != 0 ? (exp_len / ncbps) % 16 : 0);
    prev_done = done_cyc;
    exp_q.delete();
  endtask

  task automatic fill_rand(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(1'($urandom_range(0, 1)));
  endtask

  initial begin
    int n;
    bus.di = 0; bus.di_vld = 0; bus.di_last = 0; bus.rate = 0; bus.n_cbps = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(bus.di_rdy), 0);
    chk("rst_vld", 32'(bus.do_vld), 0);
    chk("rst_do", 32'(bus.dout), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_sym", 32'(bus.do_sym_num), 0);
    rst = 0;
    #1 chk("idle_rdy", 32'(bus.di_rdy), 1);
    @(posedge clk); #1;
    // single-bit frame, rate 1/2, padded to one 48-bit symbol
    src = {1'b1};
    frame("r12_one", 2'b00, 48, 0);
    chk("r12_one_prefix", 32'(cap[47:34]), 32'(14'b11011111001011));
    chk("r12_one_padzero", 32'(cap[33:0] == '0), 1);
    src.delete();
    for (int i = 0; i < 12; i++) src.push_back(1'b0);
    frame("r34_zero", 2'b10, 24, 0);
    fill_rand(12);
    frame("r23_cont", 2'b01, 48, 0);
    fill_rand(4);
    frame("nopad", 2'b00, 0, 0);
    fill_rand(20);
    frame("r34_rand", 2'b10, 40, 0);
    fill_rand(10);
    frame("r11", 2'b11, 24, 0);
    // reset on the 5th output cycle of a rate 1/2 frame
    sb_on = 0;
    bus.rate = 0; bus.n_cbps = 48; bus.di = 1; bus.di_vld = 1; bus.di_last = 0;
    n = 0;
    for (int g = 0; g < 100 && n < 5; g++) begin
      @(posedge clk); #1;
      if (bus.do_vld) n++;
    end
    chk("rstmid_reached", n, 5);
    rst = 1; bus.di_vld = 0;
    #1 chk("rstmid_rdy", 32'(bus.di_rdy), 0);
    @(posedge clk); #1;
    rst = 0;
    chk("rstmid_vld", 32'(bus.do_vld), 0);
    chk("rstmid_sym", 32'(bus.do_sym_num), 0);
    sb_on = 1; vld_cnt = 0; done_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("rstmid_no_out", vld_cnt, 0);
    chk("rstmid_no_done", done_cnt, 0);
    fill_rand(6);
    frame("after_rst", 2'b00, 48, 0);
    // back-to-back: frame 2 starts in the IDLE cycle after done
    fill_rand(12);
    frame("b2b_a", 2'b00, 24, 0);
    fill_rand(3);
    frame("b2b_b", 2'b00, 24, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pce_punc_enc.md
Name: pce_punc_enc

Overview:
- Next-generation payload channel encoder that merges convolutional encoding, puncturing and symbol padding into one single-clock block.
- Constraint length and generators are parametrised; code rate is selectable per frame (1/2, 2/3, 3/4).
- Appends the K-1 zero tail automatically, zero-pads coded bits to a whole number of OFDM symbols, counts symbols and flags frame completion.
- Sits between the payload scrambler and the interleaver in the transmit chain.

Parameters:
K, 7, constraint length; shift register holds K-1 bits.
G0, 7'o133, generator for coded bit A; MSB taps the current input bit.
G1, 7'o171, generator for coded bit B; MSB taps the current input bit.
CBPS_W, 9, width of n_cbps and of the internal per-symbol bit counter.
SYM_W, 4, width of do_sym_num.

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active high
di  in  1  information bit
di_vld  in  1  di valid
di_last  in  1  qualifies di as the last information bit of the frame
di_rdy  out  1  block accepts di this cycle; a transfer is di_vld && di_rdy
rate  in  2  00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = reserved (treated as 1/2); latched at frame start
n_cbps  in  CBPS_W  coded bits per OFDM symbol; latched at frame start; 0 = no padding
do  out  1  coded output bit
do_vld  out  1  do valid, one bit per cycle maximum, no backpressure
do_sym_num  out  SYM_W  completed OFDM symbols in the current or last frame
done  out  1  one-cycle pulse when the frame's final coded bit has been emitted

Behaviour:
- Reset:
  - FSM goes to IDLE; shift register, pending buffer, puncture phase and bit counter are cleared.
  - Outputs: di_rdy=0 in the reset cycle, do=0, do_vld=0, do_sym_num=0, done=0.
  - Reset mid-frame abandons the frame immediately; no tail, no pad, no done pulse.
- FSM states: IDLE, ENC, TAIL, PAD.
  - IDLE:
    - di_rdy=1.
    - A transfer latches rate and n_cbps, clears do_sym_num, the bit counter and the puncture phase, encodes di, then goes to ENC (or TAIL if di_last).
  - ENC:
    - di_rdy=1 when pending count is 0, or is 1 and that bit emits this cycle.
    - A transfer with di_last goes to TAIL.
  - TAIL:
    - Encodes K-1 internal zero bits, using the same pending/puncture rules and without using di.
    - Then goes to PAD, or to done if the bit counter is 0 or n_cbps==0.
  - PAD:
    - Emits zero bits until the bit counter wraps to 0.
    - Then pulses done and returns to IDLE.
- Encoding:
  - A = XOR(G0 & {in, sr}); B = XOR(G1 & {in, sr}).
  - sr shifts the input in at the MSB side: sr <= {in, sr[K-2:1]}.
- Puncturing:
  - The phase counter advances once per encoded bit (data or tail).
  - Rate 1/2: period 1, keep A,B.
  - Rate 2/3: period 2; phase0 keep A,B; phase1 keep A.
  - Rate 3/4: period 3; phase0 keep A,B; phase1 keep A; phase2 keep B.
  - Kept bits enter a 2-entry pending buffer in A-then-B order.
- Output:
  - The buffer emits its oldest bit every cycle it is non-empty.
  - Latency: bit accepted in cycle t, first coded bit has do_vld in cycle t+1.
- Counting:
  - The bit counter increments on every do_vld.
  - When it reaches n_cbps-1 and emits, it wraps to 0 and do_sym_num increments (modulo 2^SYM_W).
  - do_sym_num holds its value in IDLE until the next frame starts.
- Done:
  - done asserts in the cycle after the final coded bit.
  - di_rdy=0 in that cycle; the block is back in IDLE on the following cycle.
- Boundary cases:
  - di_vld with di_rdy=0 is ignored; the source must hold di.
  - di_last in IDLE gives a one-bit frame.
  - di_last is ignored unless it comes with a transfer.

Test Plan:
- Rate 1/2, n_cbps=48, single bit di=1 with di_last=1:
  - do = 11 01 11 11 00 10 11 (14 bits), then 34 zeros.
  - do_vld high for 48 consecutive cycles, do_sym_num=1, a single done pulse.
- Rate 3/4, 12 info bits all zero, n_cbps=24:
  - Coded length is 16 data + 8 tail = 24 bits, all zero; no pad.
  - do_sym_num=1; done one cycle after the 24th bit.
- Rate 2/3, di_vld held high continuously:
  - di_rdy duty gives exactly 3 output bits per 2 accepted bits.
  - do_vld never drops mid-frame.
- n_cbps=0, rate 1/2, 4 bits: exactly 20 coded bits, no padding, do_sym_num=0.
- rst asserted on the 5th output cycle of a rate 1/2 frame:
  - Next cycle do_vld=0 and do_sym_num=0; no done pulse.
  - A new frame then encodes from the all-zero state.
- rate=11 behaves identically to rate 00.
- Back-to-back frames: frame 2's first bit is accepted while IDLE follows done, and do_sym_num restarts from 0.
